// File: rtl/fp_test_sequencer_pkg.sv
// fp_test_sequencer_pkg: FP unit process codes, sequencer state codes and divider decode
package fp_test_sequencer_pkg;
  localparam logic [1:0] PROCESS_SINGLE_DIVIDER = 2'd0;
  localparam logic [1:0] PROCESS_DOUBLE_DIVIDER = 2'd1;
  localparam logic [1:0] PROCESS_SINGLE_SQRT    = 2'd2;
  localparam logic [1:0] PROCESS_DOUBLE_SQRT    = 2'd3;
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] OPS   = 3'd1;
  localparam logic [2:0] WAITZ = 3'd2;
  localparam logic [2:0] ACKZ  = 3'd3;
  localparam logic [2:0] FIN   = 3'd4;
  localparam logic [2:0] ERR   = 3'd5;
  function automatic logic is_divider(input logic [1:0] p);
    return p == PROCESS_SINGLE_DIVIDER || p == PROCESS_DOUBLE_DIVIDER;
  endfunction
endpackage

// File: rtl/fp_test_sequencer_if.sv
// fp_test_sequencer_if: stb/ack operand and result handshake between the sequencer and the FP unit
interface fp_test_sequencer_if #(parameter int WIDTH = 32);
  logic [1:0] process;
  logic [WIDTH-1:0] op_a, op_b, z;
  logic a_stb, b_stb, a_ack, b_ack, z_stb, z_ack;
  modport master (output process, op_a, op_b, a_stb, b_stb, z_ack, input a_ack, b_ack, z, z_stb);
  modport slave (input process, op_a, op_b, a_stb, b_stb, z_ack, output a_ack, b_ack, z, z_stb);
endinterface

// File: rtl/fp_test_sequencer_buffer.sv
// fp_test_sequencer_buffer: operand pair RAM (loaded externally, read at idx) and result RAM (written at idx, registered readback)
module fp_test_sequencer_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [WIDTH-1:0] ld_a,
  input  logic [WIDTH-1:0] ld_b,
  input  logic [AW-1:0] idx,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic res_we,
  input  logic [WIDTH-1:0] res_d,
  input  logic [AW-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [WIDTH-1:0] mem_z [DEPTH];
  always_ff @(posedge clk)
    if (ld_we) begin
      mem_a[ld_addr] <= ld_a;
      mem_b[ld_addr] <= ld_b;
    end
  always_ff @(posedge clk)
    if (res_we) mem_z[idx] <= res_d;
  always_ff @(posedge clk)
    rd_data <= !rst ? '0 : mem_z[rd_addr];
  assign op_a = mem_a[idx];
  assign op_b = mem_b[idx];
endmodule

// File: rtl/fp_test_sequencer.sv
// fp_test_sequencer: replays stored operand pairs into the FP unit and buffers each result; FP_SEQ_TIMEOUT_EN adds a per-state watchdog
module fp_test_sequencer
  import fp_test_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW = 4
`ifdef FP_SEQ_TIMEOUT_EN
  , parameter int TMO_CYC = 4096
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [WIDTH-1:0] ld_a,
  input  logic [WIDTH-1:0] ld_b,
  input  logic start,
  input  logic [AW:0] num,
  input  logic [1:0] proc_sel,
  fp_test_sequencer_if.master fpu,
  input  logic [AW-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic busy,
  output logic done,
  output logic [AW:0] idx,
  output logic err
);
  logic [2:0] state;
  logic [AW:0] num_r, idx_nx;
  logic [1:0] proc_r;
  logic a_stb, b_stb, z_ack, a_ok, b_ok, start_ok, cap;
  logic [WIDTH-1:0] buf_a, buf_b;
  assign start_ok = start && !busy;
  assign a_ok = !a_stb || fpu.a_ack;
  assign b_ok = !b_stb || fpu.b_ack;
  assign cap = state == WAITZ && fpu.z_stb;
  assign idx_nx = idx + (AW+1)'(1);
  assign fpu.process = proc_r;
  assign fpu.op_a = state == OPS ? buf_a : '0;
  assign fpu.op_b = state == OPS ? buf_b : '0;
  assign fpu.a_stb = a_stb;
  assign fpu.b_stb = b_stb;
  assign fpu.z_ack = z_ack;
  fp_test_sequencer_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk(clk),
    .rst(rst),
    .ld_we(ld_we && !busy),
    .ld_addr(ld_addr),
    .ld_a(ld_a),
    .ld_b(ld_b),
    .idx(idx[AW-1:0]),
    .op_a(buf_a),
    .op_b(buf_b),
    .res_we(cap),
    .res_d(fpu.z),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );
`ifdef FP_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo;
  logic active, progress, tmo_hit;
  assign active = state == OPS || state == WAITZ || state == ACKZ;
  assign progress = (state == OPS && a_ok && b_ok) || cap || (state == ACKZ && !fpu.z_stb);
  assign tmo_hit = active && !progress && tmo == TW'(TMO_CYC - 1);
  // the count restarts on every state change, so each wait gets its own budget
  always_ff @(posedge clk)
    tmo <= (!rst || !active || progress) ? '0 : tmo + TW'(1);
  always_ff @(posedge clk)
    err <= (!rst || start_ok) ? 1'b0 : err || tmo_hit;
`else
  assign err = 1'b0;
`endif
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      num_r <= '0;
      idx <= '0;
      proc_r <= '0;
      a_stb <= 1'b0;
      b_stb <= 1'b0;
      z_ack <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end
`ifdef FP_SEQ_TIMEOUT_EN
    else if (tmo_hit) begin
      state <= ERR;
      a_stb <= 1'b0;
      b_stb <= 1'b0;
      z_ack <= 1'b0;
      busy <= 1'b0;
      done <= 1'b1;
    end
`endif
    else if (start_ok) begin
      state <= num == '0 ? FIN : OPS;
      num_r <= num;
      idx <= '0;
      proc_r <= proc_sel;
      a_stb <= num != '0;
      b_stb <= num != '0 && is_divider(proc_sel);
      busy <= num != '0;
      done <= num == '0;
    end else
      case (state)
        OPS: begin
          if (fpu.a_ack) a_stb <= 1'b0;
          if (fpu.b_ack) b_stb <= 1'b0;
          if (a_ok && b_ok) state <= WAITZ;
        end
        WAITZ:
          if (fpu.z_stb) begin
            z_ack <= 1'b1;
            state <= ACKZ;
          end
        ACKZ:
          if (!fpu.z_stb) begin
            z_ack <= 1'b0;
            idx <= idx_nx;
            state <= idx_nx == num_r ? FIN : OPS;
            a_stb <= idx_nx != num_r;
            b_stb <= idx_nx != num_r && is_divider(proc_r);
            busy <= idx_nx != num_r;
            done <= idx_nx == num_r;
          end
        FIN: state <= IDLE;
        default: ;
      endcase
endmodule

// File: tb/tb_fp_test_sequencer.sv
// tb_fp_test_sequencer: random and directed runs against a behavioural FP-unit responder with a queue scoreboard
module tb_fp_test_sequencer;
  import fp_test_sequencer_pkg::*;
  localparam int W = 32, D = 16, AW = 4;
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic div;
    logic [1:0] proc;
  } exp_t;
  logic clk = 0, rst = 0, ld_we = 0, start = 0;
  logic [AW-1:0] ld_addr = 0, rd_addr = 0;
  logic [W-1:0] ld_a = 0, ld_b = 0, rd_data;
  logic [AW:0] num = 0, idx;
  logic [1:0] proc_sel = 0;
  logic busy, done, err;
  int errors = 0, checks = 0;
  exp_t exp_q[$];
  logic [W-1:0] ma [D];
  logic [W-1:0] mb [D];
  logic [W-1:0] mres [D];
  int f_ad = -1, f_bd = -1, f_zd = -1, f_zh = -1;
  int zack_cnt = 0, zmin = 0, zmax = 0, last_a_hi = 0, last_b_hi = 0;
  fp_test_sequencer_if #(.WIDTH(W)) fpu();
  fp_test_sequencer #(.WIDTH(W), .DEPTH(D), .AW(AW)
`ifdef FP_SEQ_TIMEOUT_EN
    , .TMO_CYC(16)
`endif
  ) dut (
    .clk(clk), .rst(rst), .ld_we(ld_we), .ld_addr(ld_addr), .ld_a(ld_a), .ld_b(ld_b),
    .start(start), .num(num), .proc_sel(proc_sel), .fpu(fpu), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .done(done), .idx(idx), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask
  // stands in for the FP unit: two known IEEE cases, otherwise an arbitrary mixing function
  function automatic logic [W-1:0] fake_fpu(input logic [W-1:0] a, input logic [W-1:0] b, input logic div);
    if (div && a == 32'h3F800000 && b == 32'h40000000) return 32'h3F000000;
    if (!div && a == 32'h40800000) return 32'h40000000;
    return div ? (a ^ {b[15:0], b[31:16]}) + 32'h1234 : ~a + 32'h55;
  endfunction
  int ms = 0, cnt = 0, ad = 0, bd = 0, zd = 0, zh = 1;
  logic m_div = 0, a_done = 0, b_done = 0;
  logic [W-1:0] m_a = 0, m_b = 0;
  initial begin
    fpu.a_ack = 0; fpu.b_ack = 0; fpu.z_stb = 0; fpu.z = 0;
    forever begin
      @(posedge clk); #1;
      fpu.a_ack = 0; fpu.b_ack = 0;
      if (!rst) begin
        ms = 0;
        fpu.z_stb = 0;
      end else begin
        if (ms == 0 && fpu.a_stb) begin
          m_div = is_divider(fpu.process); m_a = fpu.op_a; m_b = fpu.op_b;
          ad = f_ad < 0 ? int'($urandom_range(0, 4)) : f_ad;
          bd = f_bd < 0 ? int'($urandom_range(0, 4)) : f_bd;
          zd = f_zd < 0 ? int'($urandom_range(0, 6)) : f_zd;
          zh = f_zh < 0 ? int'($urandom_range(1, 3)) : f_zh;
          a_done = 0; b_done = !m_div; cnt = 0; ms = 1;
        end
        if (ms == 1) begin
          if (!a_done && cnt == ad) begin fpu.a_ack = 1; a_done = 1; end
          if (!b_done && cnt == bd) begin fpu.b_ack = 1; b_done = 1; end
          cnt++;
          if (a_done && b_done) begin ms = 2; cnt = 0; end
        end else if (ms == 2) begin
          if (cnt == zd) begin fpu.z = fake_fpu(m_a, m_b, m_div); fpu.z_stb = 1; ms = 3; cnt = 0; end
          else cnt++;
        end else if (ms == 3 && fpu.z_ack) begin
          cnt++;
          if (cnt == zh) begin fpu.z_stb = 0; ms = 0; end
        end
      end
    end
  end
  logic prev_a = 0, prev_b = 0, prev_zs = 0, prev_za = 0, zpend = 0, cur_div = 1;
  logic [W-1:0] cur_a = 0;
  int a_hi = 0, b_hi = 0, z_hi = 0;
  exp_t e_m;
  always @(negedge clk) begin
    if (!rst) begin
      prev_a = 0; prev_b = 0; prev_zs = 0; prev_za = 0; zpend = 0; a_hi = 0; b_hi = 0; z_hi = 0;
    end else begin
      if (fpu.a_stb && !prev_a) begin
        if (exp_q.size() == 0) fail("unexpected_txn");
        else begin
          e_m = exp_q.pop_front();
          chk("op_a", fpu.op_a, e_m.a);
          if (e_m.div) chk("op_b", fpu.op_b, e_m.b);
          chk("b_stb_req", fpu.b_stb, e_m.div);
          chk("process", fpu.process, e_m.proc);
          cur_a = fpu.op_a; cur_div = e_m.div;
        end
      end else if (fpu.a_stb) chk("op_a_stable", fpu.op_a, cur_a);
      if (fpu.a_stb && !cur_div) chk("b_stb_sqrt", fpu.b_stb, 0);
      if (fpu.a_stb) a_hi++;
      else begin if (prev_a) last_a_hi = a_hi; a_hi = 0; end
      if (fpu.b_stb) b_hi++;
      else begin if (prev_b) last_b_hi = b_hi; b_hi = 0; end
      if (zpend) chk("z_ack_latency", fpu.z_ack, 1);
      zpend = fpu.z_stb && !prev_zs;
      if (fpu.z_ack) begin
        if (!prev_za) zack_cnt++;
        z_hi++;
      end else begin
        if (prev_za) begin
          if (z_hi < zmin) zmin = z_hi;
          if (z_hi > zmax) zmax = z_hi;
        end
        z_hi = 0;
      end
      prev_a = fpu.a_stb; prev_b = fpu.b_stb; prev_zs = fpu.z_stb; prev_za = fpu.z_ack;
    end
  end
  task automatic ld(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    ld_we = 1; ld_addr = AW'(i); ld_a = a; ld_b = b;
    @(posedge clk); #1;
    ld_we = 0;
    ma[i] = a; mb[i] = b;
  endtask
  task automatic run(input int n, input logic [1:0] p, input bit disturb);
    exp_t e;
    int c;
    for (int i = 0; i < n; i++) begin
      e.a = ma[i]; e.b = mb[i]; e.div = is_divider(p); e.proc = p;
      exp_q.push_back(e);
      mres[i] = fake_fpu(ma[i], mb[i], e.div);
    end
    zack_cnt = 0; zmin = 1000; zmax = 0;
    num = (AW+1)'(n); proc_sel = p; start = 1;
    @(posedge clk); #1;
    start = 0;
    if (n > 0) begin
      chk("start_to_a_stb", fpu.a_stb, 1);
      chk("busy_on_start", busy, 1);
    end else begin
      chk("done_num0", done, 1);
      chk("a_stb_num0", fpu.a_stb, 0);
      chk("busy_num0", busy, 0);
    end
    if (disturb) begin
      @(posedge clk); #1;
      start = 1; num = 0; ld_we = 1; ld_addr = AW'(n - 1); ld_a = ~ma[n-1]; ld_b = ~mb[n-1];
      @(posedge clk); #1;
      start = 0; ld_we = 0;
    end
    c = 0;
    while (!done && c < 4000) begin @(posedge clk); #1; c++; end
    if (!done) fail("run_timeout");
    @(negedge clk); #1;
    chk("idx_end", idx, n);
    chk("busy_end", busy, 0);
    chk("done_end", done, 1);
    chk("err_end", err, 0);
    chk("captures", zack_cnt, n);
    chk("queue_drained", exp_q.size(), 0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rd_addr = AW'(i);
      @(posedge clk); #1;
      chk("rd_data", rd_data, mres[i]);
    end
  endtask
  task automatic reset_pulse();
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("rst_a_stb", fpu.a_stb, 0);
    chk("rst_b_stb", fpu.b_stb, 0);
    chk("rst_z_ack", fpu.z_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idx", idx, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    rst = 1;
    exp_q.delete();
  endtask
  initial begin
    #2000000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int c;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_idx", idx, 0);
    chk("reset_err", err, 0);
    chk("reset_a_stb", fpu.a_stb, 0);
    chk("reset_z_ack", fpu.z_ack, 0);
    chk("reset_process", fpu.process, 0);
    chk("reset_op_a", fpu.op_a, 0);
    chk("reset_rd_data", rd_data, 0);
    rst = 1;
    for (int i = 0; i < D; i++) ld(i, $urandom, $urandom);
    ld(0, 32'h3F800000, 32'h40000000);
    run(1, PROCESS_SINGLE_DIVIDER, 0);
    chk("div_result", rd_data, 32'h3F000000);
    ld(0, 32'h40800000, $urandom);
    run(1, PROCESS_SINGLE_SQRT, 0);
    chk("sqrt_result", rd_data, 32'h40000000);
    ld(0, 32'h3F800000, 32'h40000000);
    f_ad = 5; f_bd = 0;
    run(1, PROCESS_SINGLE_DIVIDER, 0);
    chk("a_stb_extra", last_a_hi - last_b_hi, 5);
    f_ad = -1; f_bd = -1;
    run(0, PROCESS_DOUBLE_DIVIDER, 0);
    repeat (3) begin @(posedge clk); #1; chk("idle_after_num0", fpu.a_stb, 0); end
    f_zh = 3;
    run(12, PROCESS_DOUBLE_DIVIDER, 0);
    chk("z_ack_hold_min", zmin, 3);
    chk("z_ack_hold_max", zmax, 3);
    f_zh = -1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < D; i++) ld(i, $urandom, $urandom);
      run($urandom_range(4, 16), 2'($urandom_range(0, 3)), r[0]);
    end
    f_zd = 30;
    run_start_only();
    c = 0;
    while (!(busy && !fpu.a_stb && !fpu.b_stb) && c < 50) begin @(posedge clk); #1; c++; end
    if (c == 50) fail("reach_waitz");
    reset_pulse();
    f_zd = -1;
`ifdef FP_SEQ_TIMEOUT_EN
    f_zd = 200;
    num = 1; proc_sel = PROCESS_SINGLE_DIVIDER; start = 1;
    exp_q.push_back('{ma[0], mb[0], 1'b1, PROCESS_SINGLE_DIVIDER});
    @(posedge clk); #1;
    start = 0;
    c = 0;
    while (!done && c < 300) begin @(posedge clk); #1; c++; end
    chk("tmo_err", err, 1);
    chk("tmo_done", done, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_idx", idx, 0);
    chk("tmo_a_stb", fpu.a_stb, 0);
    reset_pulse();
    f_zd = -1;
`endif
    run(5, PROCESS_DOUBLE_SQRT, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  task automatic run_start_only();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      e.a = ma[i]; e.b = mb[i]; e.div = 1'b1; e.proc = PROCESS_DOUBLE_DIVIDER;
      exp_q.push_back(e);
    end
    num = 3; proc_sel = PROCESS_DOUBLE_DIVIDER; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask
endmodule
